// File: rtl/avalon_slave_mem.sv
// Avalon-MM slave memory target.
// Mode 0 stalls each request with a configurable number of wait states.
// Mode 1 never stalls and returns read data after a fixed pipeline latency.
module avalon_slave_mem #(
    parameter int AVALONMODE  = 0,
    parameter int NBDATABYTES = 2,
    parameter int NBADDRBITS  = 8,
    parameter int WRITEDELAY  = 2,
    parameter int READDELAY   = 1,
    parameter int FIXEDDELAY  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NBADDRBITS-1:0]      address,
    input  logic [NBDATABYTES-1:0]     byteenable,
    input  logic [8*NBDATABYTES-1:0]   writedata,
    input  logic                       read,
    input  logic                       write,
    output logic                       waitrequest,
    output logic [8*NBDATABYTES-1:0]   readdata,
    output logic                       readdatavalid
);

    localparam int DW    = 8 * NBDATABYTES;
    localparam int DEPTH = 1 << NBADDRBITS;

    logic [DW-1:0] mem [DEPTH];

    // read and write together is a protocol error and is treated as no request
    logic rd_req;
    logic wr_req;
    logic wr_acc;
    logic rd_acc;

    assign rd_req = read & ~write;
    assign wr_req = write & ~read;

    // Storage: cleared on reset, byte-lane write on an accepted write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_acc) begin
            for (int unsigned b = 0; b < NBDATABYTES; b++) begin
                if (byteenable[b]) begin
                    mem[address][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    generate
        if (AVALONMODE == 0) begin : g_waitstate
            localparam int MAXD = (WRITEDELAY > READDELAY) ? WRITEDELAY : READDELAY;
            localparam int CW   = (MAXD < 2) ? 1 : $clog2(MAXD + 1);
            localparam logic [CW-1:0] WR_LOAD = CW'((WRITEDELAY > 0) ? WRITEDELAY - 1 : 0);
            localparam logic [CW-1:0] RD_LOAD = CW'(READDELAY - 1);
            localparam bit WR_STALL = (WRITEDELAY > 0);
            localparam bit RD_ONE   = (READDELAY == 1);

            typedef enum logic {S_IDLE, S_WAIT} state_t;

            state_t          state;
            state_t          state_nxt;
            logic [CW-1:0]   cnt;
            logic [CW-1:0]   cnt_nxt;
            logic            wait_c;
            logic            rd_cap;
            logic [DW-1:0]   rdata_q;

            // The first wait cycle is spent in IDLE, so the counter holds the
            // wait cycles still remaining after the current one.

            // State and counter register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end else begin
                    state <= state_nxt;
                    cnt   <= cnt_nxt;
                end
            end

            // Next-state: load on a stalled request, count down, leave on accept or abort
            always_comb begin
                state_nxt = state;
                cnt_nxt   = cnt;
                case (state)
                    S_IDLE: begin
                        if (rd_req) begin
                            state_nxt = S_WAIT;
                            cnt_nxt   = RD_LOAD;
                        end else if (wr_req && WR_STALL) begin
                            state_nxt = S_WAIT;
                            cnt_nxt   = WR_LOAD;
                        end
                    end
                    S_WAIT: begin
                        if (!(rd_req || wr_req) || cnt == '0) begin
                            state_nxt = S_IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt - CW'(1);
                        end
                    end
                    default: begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end
                endcase
            end

            // Outputs: stall while wait cycles remain; valid in the read accept cycle
            always_comb begin
                wait_c = 1'b0;
                if (!rst) begin
                    case (state)
                        S_IDLE:  wait_c = rd_req || (wr_req && WR_STALL);
                        S_WAIT:  wait_c = (rd_req || wr_req) && (cnt != '0);
                        default: wait_c = 1'b0;
                    endcase
                end
                rd_cap = rd_req && ((state == S_IDLE && RD_ONE) ||
                                    (state == S_WAIT && cnt == CW'(1)));
            end

            // Read data is captured on the edge entering the accept cycle and then held
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q <= '0;
                end else if (rd_cap) begin
                    rdata_q <= mem[address];
                end
            end

            assign waitrequest   = wait_c;
            assign wr_acc        = wr_req & ~wait_c;
            assign rd_acc        = rd_req & ~wait_c;
            assign readdatavalid = rd_acc && (state == S_WAIT);
            assign readdata      = rdata_q;
        end else begin : g_pipelined
            logic [FIXEDDELAY-1:0] vpipe;
            logic [DW-1:0]         dpipe [FIXEDDELAY];

            // Read pipeline: each stage only loads when valid data shifts in,
            // so the last stage also holds readdata between responses
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vpipe <= '0;
                    for (int unsigned i = 0; i < FIXEDDELAY; i++) begin
                        dpipe[i] <= '0;
                    end
                end else begin
                    vpipe[0] <= rd_acc;
                    if (rd_acc) begin
                        dpipe[0] <= mem[address];
                    end
                    for (int unsigned i = 1; i < FIXEDDELAY; i++) begin
                        vpipe[i] <= vpipe[i-1];
                        if (vpipe[i-1]) begin
                            dpipe[i] <= dpipe[i-1];
                        end
                    end
                end
            end

            assign waitrequest   = 1'b0;
            assign wr_acc        = wr_req;
            assign rd_acc        = rd_req;
            assign readdatavalid = vpipe[FIXEDDELAY-1];
            assign readdata      = dpipe[FIXEDDELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_avalon_slave_mem.sv
// Scoreboard bench: one wait-state instance and one pipelined instance,
// checked against a plain array memory model and expected-response queues.
module tb_avalon_slave_mem;

    localparam int WD = 2;
    localparam int RD = 1;
    localparam int FD = 2;

    typedef struct {
        logic [15:0] d;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst0, rst1;
    logic [7:0]  addr0, addr1;
    logic [1:0]  be0, be1;
    logic [15:0] wd0, wd1;
    logic        rd0, rd1, wr0, wr1;
    logic        wrq0, wrq1;
    logic [15:0] rdata0, rdata1;
    logic        rdv0, rdv1;

    logic [15:0] m0 [256];
    logic [15:0] m1 [256];
    logic [15:0] q0 [$];
    exp_t        q1 [$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    avalon_slave_mem #(
        .AVALONMODE(0), .NBDATABYTES(2), .NBADDRBITS(8),
        .WRITEDELAY(WD), .READDELAY(RD), .FIXEDDELAY(FD)
    ) u0 (
        .clk(clk), .rst(rst0), .address(addr0), .byteenable(be0),
        .writedata(wd0), .read(rd0), .write(wr0), .waitrequest(wrq0),
        .readdata(rdata0), .readdatavalid(rdv0)
    );

    avalon_slave_mem #(
        .AVALONMODE(1), .NBDATABYTES(2), .NBADDRBITS(8),
        .WRITEDELAY(WD), .READDELAY(RD), .FIXEDDELAY(FD)
    ) u1 (
        .clk(clk), .rst(rst1), .address(addr1), .byteenable(be1),
        .writedata(wd1), .read(rd1), .write(wr1), .waitrequest(wrq1),
        .readdata(rdata1), .readdatavalid(rdv1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wr_model(inout logic [15:0] word, input logic [15:0] d, input logic [1:0] be);
        if (be[0]) word[7:0]  = d[7:0];
        if (be[1]) word[15:8] = d[15:8];
    endtask

    // Mode 0 monitor: every valid pops one expected word; idle bus never stalls
    always @(negedge clk) begin
        if (rdv0 === 1'b1) begin
            if (q0.size() == 0) begin
                chk("m0 unexpected readdatavalid", {16'h0, rdata0}, 32'hFFFF_FFFF);
            end else begin
                chk("m0 readdata", {16'h0, rdata0}, {16'h0, q0.pop_front()});
            end
        end
        if (!rd0 && !wr0) chk("m0 idle waitrequest", {31'h0, wrq0}, 32'h0);
    end

    // Mode 1 monitor: data and arrival cycle against the scoreboard; never stalls
    always @(negedge clk) begin
        if (rdv1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("m1 unexpected readdatavalid", {16'h0, rdata1}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("m1 readdata", {16'h0, rdata1}, {16'h0, e.d});
                chk("m1 latency", cyc, e.due);
            end
        end
        chk("m1 waitrequest", {31'h0, wrq1}, 32'h0);
    end

    // One complete mode 0 transaction; starts and ends at posedge+1
    task automatic m0_op(input bit is_wr, input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
        int waits;
        bit done;
        addr0 = a; wd0 = d; be0 = be; wr0 = is_wr; rd0 = !is_wr;
        if (!is_wr) q0.push_back(m0[a]);
        waits = 0;
        done  = 1'b0;
        while (!done && waits < 20) begin
            @(negedge clk);
            if (wrq0 === 1'b0) done = 1'b1;
            else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        chk(is_wr ? "m0 write wait cycles" : "m0 read wait cycles", waits, is_wr ? WD : RD);
        if (is_wr && done) wr_model(m0[a], d, be);
        @(posedge clk); #1;
        rd0 = 1'b0; wr0 = 1'b0;
    endtask

    // One mode 1 bus cycle: 0 idle, 1 read, 2 write, 3 read+write
    task automatic m1_cycle(input int kind, input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
        exp_t e;
        addr1 = a; wd1 = d; be1 = be;
        rd1 = (kind == 1 || kind == 3);
        wr1 = (kind == 2 || kind == 3);
        if (kind == 1) begin
            e.d   = m1[a];
            e.due = cyc + FD;
            q1.push_back(e);
        end
        if (kind == 2) wr_model(m1[a], d, be);
        @(posedge clk); #1;
        rd1 = 1'b0; wr1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            m0[i] = '0;
            m1[i] = '0;
        end
        rst0 = 1'b1; rst1 = 1'b1;
        addr0 = '0; be0 = '0; wd0 = '0; rd0 = 1'b0; wr0 = 1'b0;
        addr1 = '0; be1 = '0; wd1 = '0; rd1 = 1'b0; wr1 = 1'b0;

        @(negedge clk);
        chk("reset m0 waitrequest", {31'h0, wrq0}, 32'h0);
        chk("reset m0 readdatavalid", {31'h0, rdv0}, 32'h0);
        chk("reset m0 readdata", {16'h0, rdata0}, 32'h0);
        chk("reset m1 readdatavalid", {31'h0, rdv1}, 32'h0);
        chk("reset m1 readdata", {16'h0, rdata1}, 32'h0);
        @(posedge clk); #1;
        rst0 = 1'b0; rst1 = 1'b0;
        @(posedge clk); #1;

        // Mode 0 directed
        m0_op(1'b0, 8'h10, 16'h0, 2'b00);
        m0_op(1'b1, 8'h05, 16'hBEEF, 2'b11);
        m0_op(1'b1, 8'h05, 16'h1234, 2'b01);
        m0_op(1'b0, 8'h05, 16'h0, 2'b00);

        // Mode 0 abort after one wait cycle: no commit
        addr0 = 8'h05; wd0 = 16'hFFFF; be0 = 2'b11; wr0 = 1'b1;
        @(negedge clk);
        chk("m0 abort stall", {31'h0, wrq0}, 32'h1);
        @(posedge clk); #1;
        wr0 = 1'b0;
        @(posedge clk); #1;
        m0_op(1'b0, 8'h05, 16'h0, 2'b00);

        // Mode 0 read and write together: no stall, no effect
        addr0 = 8'h05; wd0 = 16'h0000; be0 = 2'b11; rd0 = 1'b1; wr0 = 1'b1;
        @(negedge clk);
        chk("m0 rd&wr waitrequest", {31'h0, wrq0}, 32'h0);
        @(posedge clk); #1;
        rd0 = 1'b0; wr0 = 1'b0;
        @(posedge clk); #1;
        m0_op(1'b0, 8'h05, 16'h0, 2'b00);

        // Mode 0 random traffic
        for (int n = 0; n < 30; n++) begin
            m0_op($urandom_range(0, 1) == 1, 8'($urandom_range(0, 15)),
                  16'($urandom), 2'($urandom_range(0, 3)));
        end

        // Mode 0 reset in the middle of a write wait
        addr0 = 8'h05; wd0 = 16'h5555; be0 = 2'b11; wr0 = 1'b1;
        @(negedge clk);
        #1 rst0 = 1'b1; wr0 = 1'b0;
        #1;
        chk("m0 async reset waitrequest", {31'h0, wrq0}, 32'h0);
        chk("m0 async reset readdatavalid", {31'h0, rdv0}, 32'h0);
        chk("m0 async reset readdata", {16'h0, rdata0}, 32'h0);
        for (int i = 0; i < 256; i++) m0[i] = '0;
        q0.delete();
        @(posedge clk); #1;
        rst0 = 1'b0;
        @(posedge clk); #1;
        m0_op(1'b0, 8'h05, 16'h0, 2'b00);
        repeat (3) begin @(posedge clk); #1; end
        chk("m0 scoreboard drained", q0.size(), 0);

        // Mode 1 directed: back-to-back reads and read-after-write
        m1_cycle(2, 8'h01, 16'h0011, 2'b11);
        m1_cycle(2, 8'h02, 16'h0022, 2'b11);
        m1_cycle(2, 8'h03, 16'h0033, 2'b11);
        m1_cycle(1, 8'h01, 16'h0, 2'b00);
        m1_cycle(1, 8'h02, 16'h0, 2'b00);
        m1_cycle(1, 8'h03, 16'h0, 2'b00);
        m1_cycle(2, 8'h07, 16'hAAAA, 2'b11);
        m1_cycle(1, 8'h07, 16'h0, 2'b00);
        m1_cycle(3, 8'h07, 16'h0000, 2'b11);
        m1_cycle(1, 8'h07, 16'h0, 2'b00);

        // Mode 1 random traffic
        for (int n = 0; n < 80; n++) begin
            m1_cycle($urandom_range(0, 3), 8'($urandom_range(0, 15)),
                     16'($urandom), 2'($urandom_range(0, 3)));
        end
        repeat (FD + 2) m1_cycle(0, 8'h0, 16'h0, 2'b00);
        chk("m1 scoreboard drained", q1.size(), 0);

        // Mode 1 reset with reads outstanding
        m1_cycle(2, 8'h09, 16'hC3C3, 2'b11);
        m1_cycle(1, 8'h09, 16'h0, 2'b00);
        m1_cycle(1, 8'h09, 16'h0, 2'b00);
        rst1 = 1'b1;
        #1;
        chk("m1 async reset readdatavalid", {31'h0, rdv1}, 32'h0);
        chk("m1 async reset readdata", {16'h0, rdata1}, 32'h0);
        for (int i = 0; i < 256; i++) m1[i] = '0;
        q1.delete();
        @(posedge clk); #1;
        rst1 = 1'b0;
        repeat (FD + 2) m1_cycle(0, 8'h0, 16'h0, 2'b00);
        m1_cycle(1, 8'h09, 16'h0, 2'b00);
        repeat (FD + 2) m1_cycle(0, 8'h0, 16'h0, 2'b00);
        chk("m1 post-reset scoreboard drained", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
